// File: rtl/piece_fall.sv
`default_nettype none
// ============================================================================
// Module      : piece_fall
// Description : Falling-piece engine for an 8-row x 4-column board.
//               Takes a freshly spawned board/piece from the clear/spawn
//               stage, applies gravity ticks and lateral moves to the
//               active piece, locks it when it can no longer descend, and
//               reports the current phase back to the clear/spawn stage.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clka           in   1   clock, all state updates on the rising edge
//   restart        in   1   asynchronous reset, active low
//   board_in       in  32   board after clear/spawn, bit 4*row+col,
//                           row 0 at top, row 7 at bottom
//   board_in_valid in   1   qualifies board_in/error_in/curr_piece (GEN only)
//   curr_piece     in   2   spawned shape: 00 single, 01 pair, 10 square, 11 L
//   error_in       in   1   spawn-collision flag from clear/spawn stage
//   tick           in   1   gravity pulse
//   move_left      in   1   lateral move request towards column 0
//   move_right     in   1   lateral move request towards column 3
//   board_out      out 32   registered board including the active piece
//   state          out  3   phase code: 0 GEN, 1 FALL, 2 LOCK, 3 OVER
//   landed         out  1   high for the single LOCK cycle
//   game_over      out  1   sticky until reset
// ============================================================================
module piece_fall (
    input  logic        clka,
    input  logic        restart,
    input  logic [31:0] board_in,
    input  logic        board_in_valid,
    input  logic [1:0]  curr_piece,
    input  logic        error_in,
    input  logic        tick,
    input  logic        move_left,
    input  logic        move_right,
    output logic [31:0] board_out,
    output logic [2:0]  state,
    output logic        landed,
    output logic        game_over
);

    // ------------------------------------------------------------------------
    // Phase encoding (visible on the state port)
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_GEN  = 3'd0;
    localparam logic [2:0] c_ST_FALL = 3'd1;
    localparam logic [2:0] c_ST_LOCK = 3'd2;
    localparam logic [2:0] c_ST_OVER = 3'd3;

    // Edge masks: bottom row, leftmost column, rightmost column
    localparam logic [31:0] c_ROW_BOTTOM = 32'hF000_0000;
    localparam logic [31:0] c_COL_LEFT   = 32'h1111_1111;
    localparam logic [31:0] c_COL_RIGHT  = 32'h8888_8888;

    // Spawn masks, all placed in rows 0/1 around columns 1..2
    localparam logic [31:0] c_SPAWN_SINGLE = 32'h0000_0002;
    localparam logic [31:0] c_SPAWN_PAIR   = 32'h0000_0006;
    localparam logic [31:0] c_SPAWN_SQUARE = 32'h0000_0066;
    localparam logic [31:0] c_SPAWN_L      = 32'h0000_0062;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [31:0] r_board;
    logic [31:0] r_act;
    logic        r_landed;
    logic        r_game_over;

    logic [2:0]  w_state_nxt;
    logic [31:0] w_board_nxt;
    logic [31:0] w_act_nxt;
    logic        w_landed_nxt;
    logic        w_game_over_nxt;

    // ------------------------------------------------------------------------
    // Candidate positions and their legality
    // ------------------------------------------------------------------------
    logic [31:0] w_fixed;
    logic [31:0] w_down;
    logic [31:0] w_left;
    logic [31:0] w_right;
    logic        w_down_blk;
    logic        w_left_blk;
    logic        w_right_blk;
    logic [31:0] w_spawn;

    // Cells that belong to the settled stack, i.e. not the moving piece
    assign w_fixed = r_board & ~r_act;

    // Shifting by one row is a shift of 4 bits; one column is 1 bit. The
    // edge masks are tested on the current piece so that a shift never
    // wraps a cell into the neighbouring row.
    assign w_down  = r_act << 4;
    assign w_left  = r_act >> 1;
    assign w_right = r_act << 1;

    assign w_down_blk  = (|(r_act & c_ROW_BOTTOM)) | (|(w_down  & w_fixed));
    assign w_left_blk  = (|(r_act & c_COL_LEFT))   | (|(w_left  & w_fixed));
    assign w_right_blk = (|(r_act & c_COL_RIGHT))  | (|(w_right & w_fixed));

    always_comb begin
        w_spawn = c_SPAWN_SINGLE;
        case (curr_piece)
            2'b00:   w_spawn = c_SPAWN_SINGLE;
            2'b01:   w_spawn = c_SPAWN_PAIR;
            2'b10:   w_spawn = c_SPAWN_SQUARE;
            default: w_spawn = c_SPAWN_L;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_board_nxt     = r_board;
        w_act_nxt       = r_act;
        w_landed_nxt    = 1'b0;
        w_game_over_nxt = r_game_over;

        case (r_state)
            c_ST_GEN: begin
                if (board_in_valid) begin
                    if (error_in) begin
                        // Spawn collided: board is kept as it was
                        w_state_nxt     = c_ST_OVER;
                        w_game_over_nxt = 1'b1;
                    end else begin
                        w_board_nxt = board_in;
                        w_act_nxt   = w_spawn;
                        w_state_nxt = c_ST_FALL;
                    end
                end
            end

            c_ST_FALL: begin
                // Gravity has priority; moves in a tick cycle are dropped
                if (tick) begin
                    if (w_down_blk) begin
                        w_state_nxt  = c_ST_LOCK;
                        w_landed_nxt = 1'b1;
                    end else begin
                        w_board_nxt = w_fixed | w_down;
                        w_act_nxt   = w_down;
                    end
                end else if (move_left && !move_right) begin
                    if (!w_left_blk) begin
                        w_board_nxt = w_fixed | w_left;
                        w_act_nxt   = w_left;
                    end
                end else if (move_right && !move_left) begin
                    if (!w_right_blk) begin
                        w_board_nxt = w_fixed | w_right;
                        w_act_nxt   = w_right;
                    end
                end
            end

            c_ST_LOCK: begin
                // The piece becomes part of the stack simply by dropping it
                // from the active mask; board contents are unchanged.
                w_act_nxt   = '0;
                w_state_nxt = c_ST_GEN;
            end

            c_ST_OVER: begin
                w_game_over_nxt = 1'b1;
            end

            default: begin
                w_act_nxt   = '0;
                w_state_nxt = c_ST_GEN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clka or negedge restart) begin
        if (!restart) begin
            r_state     <= c_ST_GEN;
            r_board     <= '0;
            r_act       <= '0;
            r_landed    <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_board     <= w_board_nxt;
            r_act       <= w_act_nxt;
            r_landed    <= w_landed_nxt;
            r_game_over <= w_game_over_nxt;
        end
    end

    assign board_out = r_board;
    assign state     = r_state;
    assign landed    = r_landed;
    assign game_over = r_game_over;

endmodule
`default_nettype wire
